// File: rtl/cache_pkg.sv
// Purpose: shared types and geometry for the set-associative cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, line/beat geometry constants, tag-width helper.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_REQ,
        ST_MISS_FILL,
        ST_RESP,
        ST_WRITE_REQ
    } state_t;

    localparam int LINE_BEATS    = 4;    // 128-bit beats per 512-bit line
    localparam int OFFSET_BITS   = 4;    // word offset within a line
    localparam int MEM_BEAT_BITS = 128;
    localparam int MEM_MASK_BITS = MEM_BEAT_BITS / 8;

    // Tag = word address minus line offset minus set index.
    function automatic int tag_bits(input int word_addr_bits, input int lines, input int ways);
        return word_addr_bits - OFFSET_BITS - $clog2(lines / ways);
    endfunction

endpackage

// File: rtl/cache_assoc_if.sv
// Purpose: CPU-side and memory-side handshake bundle of the cache.
// Latency: n/a (wires only).
// Backpressure: cpu_req_valid/ready, mem_req_valid/ready, mem_req_data_valid/ready.
// Modports: slave = cache side, master = CPU pipeline + main memory side.
interface cache_assoc_if
    import cache_pkg::*;
#(
    parameter int CPU_WIDTH      = 32,
    parameter int WORD_ADDR_BITS = 30
);
    logic                        cpu_req_valid;
    logic                        cpu_req_ready;
    logic [WORD_ADDR_BITS-1:0]   cpu_req_addr;
    logic [CPU_WIDTH-1:0]        cpu_req_data;
    logic [3:0]                  cpu_req_write;
    logic                        cpu_resp_valid;
    logic [CPU_WIDTH-1:0]        cpu_resp_data;

    logic                        mem_req_valid;
    logic                        mem_req_ready;
    logic [WORD_ADDR_BITS-3:0]   mem_req_addr;
    logic                        mem_req_rw;
    logic                        mem_req_data_valid;
    logic                        mem_req_data_ready;
    logic [MEM_BEAT_BITS-1:0]    mem_req_data_bits;
    logic [MEM_MASK_BITS-1:0]    mem_req_data_mask;
    logic                        mem_resp_valid;
    logic [MEM_BEAT_BITS-1:0]    mem_resp_data;

    modport slave (
        input  cpu_req_valid, cpu_req_addr, cpu_req_data, cpu_req_write,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_rw,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output cpu_req_valid, cpu_req_addr, cpu_req_data, cpu_req_write,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_rw,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/cache_way_store.sv
// Purpose: one way of the cache: tag array, beat-organised data array, valid flops.
// Latency: tag/data read 1 cycle after rd_en; valid bit read combinationally.
// Backpressure: none; writes always complete in the cycle they are issued.
// Ports: rd_* synchronous read port, vld_set/vld valid query, data_we/tag_we write
//        port sharing wr_set (data bytes by wr_mask, tag_we also sets the valid bit).
module cache_way_store
    import cache_pkg::*;
#(
    parameter  int SETS  = 32,
    parameter  int TAG_W = 21,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rd_en,
    input  logic [IDX_W-1:0]         rd_set,
    input  logic [1:0]               rd_beat,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [MEM_BEAT_BITS-1:0] rd_data,
    input  logic [IDX_W-1:0]         vld_set,
    output logic                     vld,
    input  logic                     data_we,
    input  logic                     tag_we,
    input  logic [IDX_W-1:0]         wr_set,
    input  logic [1:0]               wr_beat,
    input  logic [MEM_BEAT_BITS-1:0] wr_data,
    input  logic [MEM_MASK_BITS-1:0] wr_mask,
    input  logic [TAG_W-1:0]         wr_tag
);

    logic [TAG_W-1:0]         tag_mem  [SETS];
    logic [MEM_BEAT_BITS-1:0] data_mem [SETS*LINE_BEATS];
    logic [SETS-1:0]          valid_q;

    // Only the valid bits are cleared; stale tags/data are harmless once invalid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[wr_set] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[wr_set] <= wr_tag;
        end
        if (data_we) begin
            for (int b = 0; b < MEM_MASK_BITS; b++) begin
                if (wr_mask[b]) begin
                    data_mem[{wr_set, wr_beat}][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_tag  <= tag_mem[rd_set];
            rd_data <= data_mem[{rd_set, rd_beat}];
        end
    end

    assign vld = valid_q[vld_set];

endmodule

// File: rtl/cache_assoc.sv
// Purpose: N-way set-associative, write-through, no-write-allocate cache.
// Latency: read hit 1 cycle after accept; read miss = mem latency + 4 beats + 2.
// Backpressure: one request at a time, cpu_req_ready only when idle; memory side
//               holds valid until ready (writes need both ready flags together).
// Ports: clk, reset (sync, active-low), bus (cache_assoc_if.slave).
module cache_assoc
    import cache_pkg::*;
#(
    parameter int LINES          = 64,
    parameter int WAYS           = 2,
    parameter int CPU_WIDTH      = 32,
    parameter int WORD_ADDR_BITS = 30
) (
    input  logic          clk,
    input  logic          reset,
    cache_assoc_if.slave  bus
);

    localparam int SETS  = LINES / WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = tag_bits(WORD_ADDR_BITS, LINES, WAYS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t                   state_q, state_d;
    logic [WORD_ADDR_BITS-1:0] addr_q;
    logic [CPU_WIDTH-1:0]     data_q;
    logic [3:0]               mask_q;
    logic [WAY_W-1:0]         victim_q;
    logic                     victim_rr_q;   // victim came from the round-robin pointer
    logic [1:0]               beat_cnt_q;
    logic [MEM_BEAT_BITS-1:0] fill_beat_q;   // beat holding the requested word
    logic [WAY_W-1:0]         rr_ptr_q [SETS];

    logic                     accept, is_write, hit, victim_rr;
    logic [WAY_W-1:0]         hit_way, victim;
    logic [IDX_W-1:0]         req_idx, idx_q;
    logic [TAG_W-1:0]         tag_q;
    logic [1:0]               beat_q, word_q;

    logic [WAYS-1:0]          way_valid, hit_vec, data_we, tag_we;
    logic [TAG_W-1:0]         way_tag  [WAYS];
    logic [MEM_BEAT_BITS-1:0] way_data [WAYS];
    logic [1:0]               st_beat;
    logic [MEM_BEAT_BITS-1:0] st_data, slot_data;
    logic [MEM_MASK_BITS-1:0] st_mask, slot_mask;
    logic [CPU_WIDTH-1:0]     hit_word, fill_word;

    logic                      req_ready, resp_valid, mreq_valid, mreq_rw, mreq_dvalid;
    logic [CPU_WIDTH-1:0]      resp_data;
    logic [WORD_ADDR_BITS-3:0] mreq_addr;
    logic [MEM_BEAT_BITS-1:0]  mreq_bits;
    logic [MEM_MASK_BITS-1:0]  mreq_mask;

    assign accept   = bus.cpu_req_valid && (state_q == ST_IDLE);
    assign is_write = |mask_q;
    assign req_idx  = bus.cpu_req_addr[OFFSET_BITS +: IDX_W];
    assign idx_q    = addr_q[OFFSET_BITS +: IDX_W];
    assign tag_q    = addr_q[WORD_ADDR_BITS-1 -: TAG_W];
    assign beat_q   = addr_q[3:2];
    assign word_q   = addr_q[1:0];

    // Tag/data are read on the accept edge so LOOKUP sees them one cycle later.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_store #(.SETS(SETS), .TAG_W(TAG_W)) u_store (
            .clk     (clk),
            .reset   (reset),
            .rd_en   (accept),
            .rd_set  (req_idx),
            .rd_beat (bus.cpu_req_addr[3:2]),
            .rd_tag  (way_tag[w]),
            .rd_data (way_data[w]),
            .vld_set (idx_q),
            .vld     (way_valid[w]),
            .data_we (data_we[w]),
            .tag_we  (tag_we[w]),
            .wr_set  (idx_q),
            .wr_beat (st_beat),
            .wr_data (st_data),
            .wr_mask (st_mask),
            .wr_tag  (tag_q)
        );
        assign hit_vec[w] = way_valid[w] && (way_tag[w] == tag_q);
    end

    // Hit encode, victim pick (lowest invalid way, else set pointer), word slotting.
    always_comb begin
        hit_way   = '0;
        victim    = rr_ptr_q[idx_q];
        victim_rr = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim    = WAY_W'(w);
                victim_rr = 1'b0;
            end
        end
        slot_data = '0;
        slot_mask = '0;
        slot_data[CPU_WIDTH*word_q +: CPU_WIDTH] = data_q;
        slot_mask[4*word_q +: 4]                 = mask_q;
    end

    assign hit       = |hit_vec;
    assign hit_word  = way_data[hit_way][CPU_WIDTH*word_q +: CPU_WIDTH];
    assign fill_word = fill_beat_q[CPU_WIDTH*word_q +: CPU_WIDTH];

    // Store writes: byte merge on a write hit, full beats from memory during a fill.
    always_comb begin
        data_we = '0;
        tag_we  = '0;
        st_beat = beat_q;
        st_data = slot_data;
        st_mask = slot_mask;
        if (state_q == ST_LOOKUP && is_write) begin
            data_we = hit_vec;
        end
        if (state_q == ST_MISS_FILL && bus.mem_resp_valid) begin
            data_we = WAYS'(1) << victim_q;
            st_beat = beat_cnt_q;
            st_data = bus.mem_resp_data;
            st_mask = '1;
            if (beat_cnt_q == 2'(LINE_BEATS - 1)) begin
                tag_we = WAYS'(1) << victim_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        mreq_valid  = 1'b0;
        mreq_rw     = 1'b0;
        mreq_dvalid = 1'b0;
        mreq_addr   = '0;
        mreq_bits   = '0;
        mreq_mask   = '0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.cpu_req_valid) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (is_write) begin
                    state_d = ST_WRITE_REQ;
                end else if (hit) begin
                    resp_valid = 1'b1;
                    resp_data  = hit_word;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_MISS_REQ;
                end
            end
            ST_MISS_REQ: begin
                mreq_valid = 1'b1;
                mreq_addr  = {addr_q[WORD_ADDR_BITS-1:OFFSET_BITS], 2'b00};
                if (bus.mem_req_ready) state_d = ST_MISS_FILL;
            end
            ST_MISS_FILL: begin
                if (bus.mem_resp_valid && beat_cnt_q == 2'(LINE_BEATS - 1)) state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_data  = fill_word;
                state_d    = ST_IDLE;
            end
            ST_WRITE_REQ: begin
                mreq_valid  = 1'b1;
                mreq_dvalid = 1'b1;
                mreq_rw     = 1'b1;
                mreq_addr   = addr_q[WORD_ADDR_BITS-1:2];
                mreq_bits   = slot_data;
                mreq_mask   = slot_mask;
                if (bus.mem_req_ready && bus.mem_req_data_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            victim_q    <= '0;
            victim_rr_q <= 1'b0;
            beat_cnt_q  <= '0;
            fill_beat_q <= '0;
            for (int s = 0; s < SETS; s++) rr_ptr_q[s] <= '0;
        end else begin
            if (accept) begin
                addr_q <= bus.cpu_req_addr;
                data_q <= bus.cpu_req_data;
                mask_q <= bus.cpu_req_write;
            end
            if (state_q == ST_LOOKUP) begin
                victim_q    <= victim;
                victim_rr_q <= victim_rr;
            end
            if (state_q == ST_MISS_REQ && bus.mem_req_ready) begin
                beat_cnt_q <= '0;
            end
            if (state_q == ST_MISS_FILL && bus.mem_resp_valid) begin
                beat_cnt_q <= beat_cnt_q + 2'd1;
                if (beat_cnt_q == beat_q) fill_beat_q <= bus.mem_resp_data;
                // Pointer only moves when it actually chose the victim.
                if (beat_cnt_q == 2'(LINE_BEATS - 1) && victim_rr_q) begin
                    rr_ptr_q[idx_q] <= (rr_ptr_q[idx_q] == WAY_W'(WAYS - 1)) ? '0
                                       : rr_ptr_q[idx_q] + WAY_W'(1);
                end
            end
        end
    end

    assign bus.cpu_req_ready      = req_ready;
    assign bus.cpu_resp_valid     = resp_valid;
    assign bus.cpu_resp_data      = resp_data;
    assign bus.mem_req_valid      = mreq_valid;
    assign bus.mem_req_addr       = mreq_addr;
    assign bus.mem_req_rw         = mreq_rw;
    assign bus.mem_req_data_valid = mreq_dvalid;
    assign bus.mem_req_data_bits  = mreq_bits;
    assign bus.mem_req_data_mask  = mreq_mask;

endmodule

// File: tb/tb_cache_assoc.sv
// Purpose: self-checking bench for cache_assoc (LINES=64, WAYS=2).
// Latency: n/a.
// Backpressure: memory readies and beat gaps are randomised.
module tb_cache_assoc;

    localparam int SETS = 32;
    localparam int WAYS = 2;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    cache_assoc_if #(.CPU_WIDTH(32), .WORD_ADDR_BITS(30)) bus ();

    cache_assoc #(.LINES(64), .WAYS(WAYS), .CPU_WIDTH(32), .WORD_ADDR_BITS(30)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: main memory contents and which line tags each set holds.
    logic [31:0] mem_m [logic [29:0]];
    bit          vld_m [SETS][WAYS];
    logic [20:0] tag_m [SETS][WAYS];
    int          ptr_m [SETS];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [29:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return 32'(a) * 32'h9E37_79B1 + 32'h1357_2468;
    endfunction

    function automatic logic [127:0] beat_data(input logic [25:0] line, input logic [1:0] b);
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[32*i +: 32] = rd_word({line, b, 2'(i)});
        return v;
    endfunction

    function automatic bit model_hit(input logic [29:0] a);
        for (int w = 0; w < WAYS; w++)
            if (vld_m[int'(a[8:4])][w] && tag_m[int'(a[8:4])][w] == a[29:9]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_fill(input logic [29:0] a);
        int s, v;
        s = int'(a[8:4]);
        v = -1;
        for (int w = 0; w < WAYS; w++) if (v < 0 && !vld_m[s][w]) v = w;
        if (v < 0) begin
            v = ptr_m[s];
            ptr_m[s] = (ptr_m[s] + 1) % WAYS;
        end
        vld_m[s][v] = 1'b1;
        tag_m[s][v] = a[29:9];
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            ptr_m[s] = 0;
            for (int w = 0; w < WAYS; w++) vld_m[s][w] = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_resp_v"}, bus.cpu_resp_valid, 0);
        chk({pfx, "_resp_d"}, bus.cpu_resp_data, 0);
        chk({pfx, "_mreq_v"}, bus.mem_req_valid, 0);
        chk({pfx, "_mreq_dv"}, bus.mem_req_data_valid, 0);
        chk({pfx, "_mreq_rw"}, bus.mem_req_rw, 0);
        chk({pfx, "_mreq_a"}, bus.mem_req_addr, 0);
        chk({pfx, "_mreq_bits"}, bus.mem_req_data_bits, 0);
        chk({pfx, "_mreq_mask"}, bus.mem_req_data_mask, 0);
    endtask

    // One CPU access with an embedded memory responder. exp_hit: 0/1 directed
    // expectation for reads, 2 = no directed expectation. abort_at > 0 pulls
    // reset after that many fill beats and feeds the rest into an idle cache.
    task automatic do_access(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                             input int exp_hit, input int abort_at);
        bit           mh, fill_on, done, prev_resp, r1, r2;
        int           c, resp_c, last_beat_c, nresp, nrd, nwr, beats;
        logic [31:0]  w;
        mh = model_hit(a);
        fill_on = 0; done = 0; prev_resp = 0;
        resp_c = 0; last_beat_c = 0; nresp = 0; nrd = 0; nwr = 0; beats = 0;
        @(negedge clk);
        chk("req_rdy", bus.cpu_req_ready, 1);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = a;
        bus.cpu_req_data  = d;
        bus.cpu_req_write = m;
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_addr  = 30'($urandom);
        bus.cpu_req_data  = $urandom;
        bus.cpu_req_write = 4'($urandom);
        c = 1;
        while (!done && c < 300) begin
            if (bus.cpu_resp_valid) begin
                nresp++;
                if (prev_resp) chk("resp_b2b", 1, 0);
                prev_resp = 1;
                resp_c = c;
                chk("rdata", bus.cpu_resp_data, rd_word(a));
                if (m == 4'd0) done = 1;
            end else begin
                prev_resp = 0;
            end
            bus.mem_resp_valid     = 1'b0;
            bus.mem_req_ready      = 1'b0;
            bus.mem_req_data_ready = 1'b0;
            if (bus.mem_req_valid && !fill_on) begin
                if (bus.mem_req_rw) begin
                    r1 = 1'($urandom); r2 = 1'($urandom);
                    bus.mem_req_ready = r1;
                    bus.mem_req_data_ready = r2;
                    if (r1 && r2) begin
                        nwr++;
                        chk("wr_addr", bus.mem_req_addr, a[29:2]);
                        chk("wr_dv", bus.mem_req_data_valid, 1);
                        chk("wr_bits", bus.mem_req_data_bits, 128'(d) << (32 * a[1:0]));
                        chk("wr_mask", bus.mem_req_data_mask, 16'(m) << (4 * a[1:0]));
                        w = rd_word(a);
                        for (int k = 0; k < 4; k++) if (m[k]) w[8*k +: 8] = d[8*k +: 8];
                        mem_m[a] = w;
                        done = 1;
                    end
                end else begin
                    r1 = 1'($urandom);
                    bus.mem_req_ready = r1;
                    if (r1) begin
                        nrd++;
                        chk("rd_addr", bus.mem_req_addr, {a[29:4], 2'b00});
                        fill_on = 1;
                        beats = 0;
                    end
                end
            end else if (fill_on && abort_at > 0 && beats == abort_at) begin
                reset = 1'b0;
                @(negedge clk);
                chk_reset_outputs("rst");
                reset = 1'b1;
                for (int k = beats; k < 4; k++) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = beat_data(a[29:4], 2'(k));
                    @(negedge clk);
                    chk("ign_resp_v", bus.cpu_resp_valid, 0);
                    chk("ign_mreq_v", bus.mem_req_valid, 0);
                end
                bus.mem_resp_valid = 1'b0;
                model_clear();
                return;
            end else if (fill_on && ($urandom_range(0, 2) != 0)) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = beat_data(a[29:4], 2'(beats));
                beats++;
                last_beat_c = c;
                if (beats == 4) fill_on = 0;
            end
            @(negedge clk);
            c++;
        end
        bus.mem_resp_valid     = 1'b0;
        bus.mem_req_ready      = 1'b0;
        bus.mem_req_data_ready = 1'b0;
        chk("done", done, 1);
        chk("end_idle", bus.cpu_req_ready, 1);
        chk("end_resp_v", bus.cpu_resp_valid, 0);
        if (m == 4'd0) begin
            chk("nresp", nresp, 1);
            chk("hit_model", nrd == 0, mh);
            if (exp_hit != 2) chk("hit_dir", nrd == 0, exp_hit != 0);
            if (mh) chk("hit_lat", resp_c, 1);
            else    chk("miss_lat", resp_c, last_beat_c + 1);
            if (!mh) model_fill(a);
        end else begin
            chk("nwr", nwr, 1);
            chk("wr_nrd", nrd, 0);
            chk("wr_noresp", nresp, 0);
        end
    endtask

    initial begin
        logic [29:0] ra;
        logic [3:0]  rm;
        reset                  = 1'b0;
        bus.cpu_req_valid      = 1'b0;
        bus.cpu_req_addr       = '0;
        bus.cpu_req_data       = '0;
        bus.cpu_req_write      = '0;
        bus.mem_req_ready      = 1'b0;
        bus.mem_req_data_ready = 1'b0;
        bus.mem_resp_valid     = 1'b0;
        bus.mem_resp_data      = '0;
        model_clear();
        repeat (2) @(negedge clk);
        chk_reset_outputs("init");
        reset = 1'b1;

        do_access(30'h40, 0, 4'h0, 0, 0);     // cold miss, beat addr 0x10
        do_access(30'h41, 0, 4'h0, 1, 0);     // hit, word 1 of beat 0
        do_access(30'h000, 0, 4'h0, 0, 0);    // A  (set 0)
        do_access(30'h200, 0, 4'h0, 0, 0);    // B  (set 0)
        do_access(30'h400, 0, 4'h0, 0, 0);    // C evicts A
        do_access(30'h200, 0, 4'h0, 1, 0);    // B still present
        do_access(30'h000, 0, 4'h0, 0, 0);    // A gone
        do_access(30'h42, 32'hDEAD_BEEF, 4'b0011, 2, 0);
        do_access(30'h42, 0, 4'h0, 1, 0);     // merged word
        do_access(30'h1230, 32'h0BAD_F00D, 4'hF, 2, 0);
        do_access(30'h1230, 0, 4'h0, 0, 0);   // no write allocate
        do_access(30'h2340, 0, 4'h0, 0, 2);   // reset mid-fill
        do_access(30'h2340, 0, 4'h0, 0, 0);
        do_access(30'h41, 0, 4'h0, 0, 0);     // all lines invalidated by reset

        for (int i = 0; i < 250; i++) begin
            ra = '0;
            ra[29]   = 1'($urandom);
            ra[10:9] = 2'($urandom);
            ra[5:4]  = 2'($urandom);
            ra[3:0]  = 4'($urandom);
            rm = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            do_access(ra, $urandom, rm, 2, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
